// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared definitions for the data memory responder.
//               - busSize access codes (RV32I funct3 load/store encoding)
//               - FSM state enumeration
//               - small helpers for size classification and lane selection
// Revision    : 1.0  initial release
// ============================================================================
package dmem_pkg;

    localparam logic [2:0] C_SIZE_B  = 3'b000;
    localparam logic [2:0] C_SIZE_H  = 3'b001;
    localparam logic [2:0] C_SIZE_W  = 3'b010;
    localparam logic [2:0] C_SIZE_BU = 3'b100;
    localparam logic [2:0] C_SIZE_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Bit 2 only selects sign/zero extension, so width is carried by [1:0].
    // Codes 011/110/111 fall through to word access.
    function automatic logic size_is_byte(input logic [2:0] s);
        return (s[1:0] == C_SIZE_B[1:0]);
    endfunction

    function automatic logic size_is_half(input logic [2:0] s);
        return (s[1:0] == C_SIZE_H[1:0]);
    endfunction

    // Starting byte lane of an access. Low address bits that a wider access
    // cannot use are treated as zero.
    function automatic logic [1:0] lane_of(input logic [2:0] s, input logic [1:0] a);
        if (size_is_byte(s)) begin
            return a;
        end else if (size_is_half(s)) begin
            return {a[1], 1'b0};
        end else begin
            return 2'b00;
        end
    endfunction

    function automatic logic is_misaligned(input logic [2:0] s, input logic [1:0] a);
        if (size_is_byte(s)) begin
            return 1'b0;
        end else if (size_is_half(s)) begin
            return a[0];
        end else begin
            return (a != 2'b00);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ram
// Description : Word-organised data array, 32-bit words, per-byte write
//               enables, synchronous write and combinational read.
//               Contents are never reset.
// Ports       : clk      - clock
//               we_i     - write strobe
//               be_i     - byte-lane write enables (bit i -> bits 8i+7:8i)
//               waddr_i  - write word index
//               wdata_i  - write data (lane-aligned)
//               raddr_i  - read word index
//               rdata_o  - read data (combinational)
// Revision    : 1.0  initial release
// ============================================================================
module dmem_ram #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Single-outstanding data memory slave with programmable wait
//               states. FSM IDLE -> WAIT -> RESP -> IDLE. Loads return
//               extended lane data registered on entry to RESP; stores commit
//               on the edge that ends RESP.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               busReq/busWe/busAddr/busWData/busSize - request (held until
//                                        busReady)
//               busRData              - registered load data
//               busReady              - one-cycle completion pulse
//               busErr                - misaligned flag, valid with busReady
// Config      : DMEM_MISALIGN_CHK_EN  - when defined, misaligned half/word
//               accesses are flagged, stores suppressed, load data forced 0.
//               When undefined, unusable low address bits are ignored.
// Revision    : 1.0  initial release
// ============================================================================
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        busReq,
    input  logic        busWe,
    input  logic [31:0] busAddr,
    input  logic [31:0] busWData,
    input  logic [2:0]  busSize,
    output logic [31:0] busRData,
    output logic        busReady,
    output logic        busErr
);

    localparam int         AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] C_WAIT = WAIT_CYCLES[3:0];

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [2:0]      size_q;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic            w_cap;
    logic            w_in_idle;
    logic            w_we;
    logic [AW+1:0]   w_addr;
    logic [2:0]      w_size;
    logic            w_err;
    logic [31:0]     w_rword;
    logic [31:0]     w_shifted;
    logic [31:0]     w_load;
    logic [1:0]      w_ld_lane;
    logic [1:0]      w_st_lane;
    logic [3:0]      w_be;
    logic [31:0]     w_st_data;
    logic            w_ram_we;
    logic            w_unused_ok;

    assign w_unused_ok = &{1'b0, busAddr[31:AW+2]};

    // With zero wait states RESP is entered straight from IDLE, before the
    // capture registers are loaded, so the load path reads the live bus.
    assign w_in_idle = (state_q == ST_IDLE);
    assign w_we      = w_in_idle ? busWe             : we_q;
    assign w_addr    = w_in_idle ? busAddr[AW+1:0]   : addr_q;
    assign w_size    = w_in_idle ? busSize           : size_q;

`ifdef DMEM_MISALIGN_CHK_EN
    assign w_err  = is_misaligned(w_size, w_addr[1:0]);
    assign busErr = err_q;
`else
    assign w_err  = 1'b0;
    assign busErr = 1'b0;
`endif

    // ---------------- load lane extraction / extension ----------------
    assign w_ld_lane = lane_of(w_size, w_addr[1:0]);
    assign w_shifted = w_rword >> {w_ld_lane, 3'b000};

    always_comb begin
        w_load = w_shifted;
        if (size_is_byte(w_size)) begin
            w_load = w_size[2] ? {24'h0, w_shifted[7:0]}
                               : {{24{w_shifted[7]}}, w_shifted[7:0]};
        end else if (size_is_half(w_size)) begin
            w_load = w_size[2] ? {16'h0, w_shifted[15:0]}
                               : {{16{w_shifted[15]}}, w_shifted[15:0]};
        end
    end

    // ---------------- store lane placement ----------------
    assign w_st_lane = lane_of(size_q, addr_q[1:0]);

    always_comb begin
        w_be      = 4'b1111;
        w_st_data = wdata_q;
        if (size_is_byte(size_q)) begin
            w_be      = 4'b0001 << w_st_lane;
            w_st_data = {4{wdata_q[7:0]}};
        end else if (size_is_half(size_q)) begin
            w_be      = 4'b0011 << w_st_lane;
            w_st_data = {2{wdata_q[15:0]}};
        end
    end

    // Reset on the edge ending RESP discards the pending store.
    assign w_ram_we = (state_q == ST_RESP) && we_q && !err_q && !reset;

    // ---------------- FSM next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        w_cap   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (busReq) begin
                    w_cap = 1'b1;
                    if (C_WAIT != 4'd0) begin
                        state_d = ST_WAIT;
                        cnt_d   = C_WAIT;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                    cnt_d   = 4'd0;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // Response data/flag are registered as RESP is entered.
        if ((state_d == ST_RESP) && (state_q != ST_RESP)) begin
            err_d = w_err;
            if (w_err) begin
                rdata_d = 32'h0;
            end else if (!w_we) begin
                rdata_d = w_load;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            size_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (w_cap) begin
                we_q    <= busWe;
                addr_q  <= busAddr[AW+1:0];
                wdata_q <= busWData;
                size_q  <= busSize;
            end
        end
    end

    assign busRData = rdata_q;
    assign busReady = (state_q == ST_RESP);

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (w_ram_we),
        .be_i    (w_be),
        .waddr_i (addr_q[AW+1:2]),
        .wdata_i (w_st_data),
        .raddr_i (w_addr[AW+1:2]),
        .rdata_o (w_rword)
    );

endmodule
`default_nettype wire
